// File: rtl/dsp_mac_seq_pkg.sv
// Shared types and constants for the sequential DSP-slice FIR MAC.
package dsp_pkg;
  localparam int D_W = 18;
  localparam int P_W = 48;

  localparam logic [7:0] OPM_FIRST = 8'h01; // X=M, Z=0
  localparam logic [7:0] OPM_ACC   = 8'h09; // X=M, Z=P
  localparam logic [7:0] OPM_HOLD  = 8'h08; // X=0, Z=P

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;
endpackage

// File: rtl/dsp_mac_seq_if.sv
// Sample-in / result-out valid-ready streams of the FIR MAC.
interface dsp_mac_seq_if;
  import dsp_pkg::*;

  logic           s_valid;
  logic           s_ready;
  logic [D_W-1:0] s_data;
  logic           m_valid;
  logic           m_ready;
  logic [P_W-1:0] m_data;

  modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/dsp_mac_seq_tap_store.sv
// Sample delay line plus coefficient file, read one tap per cycle.
module dsp_tap_store
  import dsp_pkg::*;
#(
  parameter int TAPS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    shift_i,
  input  logic                    flush_i,
  input  logic [D_W-1:0]          s_data_i,
  input  logic                    we_i,
  input  logic [$clog2(TAPS)-1:0] waddr_i,
  input  logic [D_W-1:0]          wdata_i,
  input  logic [$clog2(TAPS)-1:0] raddr_i,
  output logic [D_W-1:0]          rd_x_o,
  output logic [D_W-1:0]          rd_h_o
);
  logic [TAPS-1:0][D_W-1:0] x_q, x_d, h_q, h_d;

  always_comb begin
    x_d = x_q;
    h_d = h_q;
    if (flush_i) x_d = '0;
    if (shift_i) x_d = {x_d[TAPS-2:0], s_data_i};
    if (we_i && int'(waddr_i) < TAPS) h_d[waddr_i] = wdata_i;
  end

  // Reads see next-state contents so tap 0 of a new sample picks up that
  // sample and any coefficient written in the same cycle.
  assign rd_x_o = x_d[raddr_i];
  assign rd_h_o = h_d[raddr_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      h_q <= '0;
    end else begin
      x_q <= x_d;
      h_q <= h_d;
    end
  end
endmodule

// File: rtl/dsp_mac_seq.sv
// Sequencer feeding one external DSP slice: one tap per cycle, then drain and hand off the sum.
module dsp_mac_seq
  import dsp_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [D_W-1:0]          coef_data,
  input  logic                    flush,
  dsp_mac_seq_if.slave            sm,
  output logic [D_W-1:0]          a_out,
  output logic [D_W-1:0]          b_out,
  output logic [7:0]              opmode_out,
  output logic                    ce_slice,
  input  logic [P_W-1:0]          p_in,
  output logic                    busy
);
  localparam int KW = $clog2(TAPS);
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [P_W-1:0] m_data_q, m_data_d;
  logic [D_W-1:0] a_q, a_d, b_q, b_d, rd_x, rd_h;
  logic [7:0]     opm_q, opm_d;
  logic           rdy_q, idle, xfer;

  assign idle       = (state_q == IDLE);
  assign sm.s_ready = idle && rdy_q;
  assign xfer       = sm.s_valid && sm.s_ready;
  assign sm.m_valid = (state_q == OUT);
  assign sm.m_data  = m_data_q;
  assign ce_slice   = (state_q == ISSUE) || (state_q == DRAIN);
  assign busy       = !idle;
  assign a_out      = a_q;
  assign b_out      = b_q;
  assign opmode_out = opm_q;

  dsp_tap_store #(.TAPS(TAPS)) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_i  (xfer),
    .flush_i  (flush && idle),
    .s_data_i (sm.s_data),
    .we_i     (coef_we && idle),
    .waddr_i  (coef_addr),
    .wdata_i  (coef_data),
    .raddr_i  (k_d),
    .rd_x_o   (rd_x),
    .rd_h_o   (rd_h)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;
    case (state_q)
      IDLE: if (xfer) begin
        state_d = ISSUE;
        k_d     = '0;
      end
      ISSUE: if (k_q == KW'(TAPS - 1)) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else begin
        k_d = k_q + KW'(1);
      end
      DRAIN: if (cnt_q == CW'(PIPE_LAT - 1)) begin
        state_d  = OUT;
        m_data_d = p_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      OUT: if (sm.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Operands sit on A/B during the ISSUE cycle of their tap; opmode trails by one.
    a_d   = (state_d == ISSUE) ? rd_x : '0;
    b_d   = (state_d == ISSUE) ? rd_h : '0;
    opm_d = (state_q == ISSUE) ? ((k_q == '0) ? OPM_FIRST : OPM_ACC) : OPM_HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      m_data_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opm_q    <= OPM_HOLD;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opm_q    <= opm_d;
      rdy_q    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Random and directed checks of dsp_mac_seq against a dot-product reference and a behavioural slice.
module tb_dsp_mac_seq;
  import dsp_pkg::*;
  localparam int TAPS = 4;
  localparam int PL   = 3;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic           coef_we = 1'b0, flush = 1'b0;
  logic [1:0]     coef_addr = '0;
  logic [D_W-1:0] coef_data = '0;
  logic [D_W-1:0] a_out, b_out;
  logic [7:0]     opmode_out;
  logic           ce_slice, busy;
  logic [P_W-1:0] p_in;

  dsp_mac_seq_if bus();

  dsp_mac_seq #(.TAPS(TAPS), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .flush(flush), .sm(bus), .a_out(a_out), .b_out(b_out),
    .opmode_out(opmode_out), .ce_slice(ce_slice), .p_in(p_in), .busy(busy)
  );

  // Slice: A1/B1 reg, M reg, P reg, opmode reg; bit0 selects X=M, bit3 selects Z=P.
  logic [D_W-1:0] a_r = '0, b_r = '0;
  logic [P_W-1:0] m_r = '0, p_r = '0;
  logic [7:0]     o_r = 8'h08;
  always @(posedge clk) if (ce_slice) begin
    a_r <= a_out;
    b_r <= b_out;
    m_r <= 48'(a_r) * 48'(b_r);
    o_r <= opmode_out;
    p_r <= (o_r[0] ? m_r : 48'd0) + (o_r[3] ? p_r : 48'd0);
  end
  assign p_in = p_r;

  // Reference: coefficient file and sample history as plain arrays.
  logic [D_W-1:0] hm [TAPS];
  logic [D_W-1:0] xm [TAPS];
  int n_err = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [P_W-1:0] ref_out();
    logic [63:0] s = 0;
    for (int k = 0; k < TAPS; k++) s += 64'(hm[k]) * 64'(xm[k]);
    return s[P_W-1:0];
  endfunction

  task automatic do_reset(input string tag);
    logic seen = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_a"}, a_out, 0);
    chk({tag, "_b"}, b_out, 0);
    chk({tag, "_opm"}, opmode_out, 8'h08);
    chk({tag, "_srdy"}, bus.s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mv"}, bus.m_valid, 0);
    chk({tag, "_md"}, bus.m_data, 0);
    chk({tag, "_ce"}, ce_slice, 0);
    for (int k = 0; k < TAPS; k++) begin hm[k] = '0; xm[k] = '0; end
    repeat (2) @(negedge clk);
    chk({tag, "_srdy_hold"}, bus.s_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_srdy_rel"}, bus.s_ready, 1);
    repeat (10) begin
      if (bus.m_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_no_mv"}, seen, 0);
  endtask

  task automatic wr_coefs(input logic [D_W-1:0] h0, h1, h2, h3);
    logic [D_W-1:0] hv [TAPS];
    hv = '{h0, h1, h2, h3};
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 2'(k); coef_data = hv[k];
      hm[k] = hv[k];
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Returns at the negedge of ISSUE cycle 0.
  task automatic push(input logic [D_W-1:0] x, input bit we, input logic [1:0] wa,
                      input logic [D_W-1:0] wd, input bit fl);
    int n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = x;
    coef_we = we; coef_addr = wa; coef_data = wd; flush = fl;
    while (!bus.s_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.s_ready) chk("tmo_sready", 0, 1);
    @(negedge clk);
    bus.s_valid = 1'b0; coef_we = 1'b0; flush = 1'b0;
    if (fl) for (int k = 0; k < TAPS; k++) xm[k] = '0;
    if (we) hm[wa] = wd;
    for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = x;
  endtask

  task automatic collect(input string tag, input int stall, input int lat,
                         output logic [P_W-1:0] got);
    int n = 0;
    logic [P_W-1:0] e, d0, p0;
    e = ref_out();
    got = '0;
    while (!bus.m_valid && n < 40) begin @(negedge clk); n++; end
    if (!bus.m_valid) begin chk({tag, "_tmo"}, 0, 1); return; end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk(tag, bus.m_data, e);
    got = bus.m_data; d0 = bus.m_data; p0 = p_in;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_st_mv"}, bus.m_valid, 1);
      chk({tag, "_st_md"}, bus.m_data, d0);
      chk({tag, "_st_p"}, p_in, p0);
      chk({tag, "_st_ce"}, ce_slice, 0);
      chk({tag, "_st_srdy"}, bus.s_ready, 0);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  logic [P_W-1:0] r;

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    #2;
    do_reset("rst0");

    // Basic FIR, tap timing at the slice boundary.
    wr_coefs(18'd1, 18'd2, 18'd3, 18'd4);
    push(18'd5, 0, 0, 0, 0);
    chk("t1_busy", busy, 1);
    chk("t1_a0", a_out, 5);
    chk("t1_b0", b_out, 1);
    chk("t1_ce", ce_slice, 1);
    @(negedge clk);
    chk("t1_opm_first", opmode_out, 8'h01);
    chk("t1_b1", b_out, 2);
    @(negedge clk);
    chk("t1_opm_acc", opmode_out, 8'h09);
    collect("t1", 0, TAPS + PL - 2, r);
    chk("t1_const", r, 5);
    push(18'd7, 0, 0, 0, 0);
    collect("t2", 10, TAPS + PL, r);
    chk("t2_const", r, 17);
    push(18'd1, 0, 0, 0, 0);
    collect("t3", 0, TAPS + PL, r);
    chk("t3_const", r, 30);

    // Coefficient write while busy is dropped; in IDLE it lands with the sample.
    push(18'd4, 0, 0, 0, 0);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 18'd9;
    @(negedge clk);
    coef_we = 1'b0;
    collect("t4_ign", 0, TAPS + PL - 1, r);
    chk("t4_const", r, 47);
    push(18'd2, 1, 2'd0, 18'd9, 0);
    collect("t5_wr", 0, TAPS + PL, r);
    chk("t5_const", r, 57);

    // Flush concurrent with a sample.
    push(18'd3, 0, 0, 0, 1);
    collect("t6_fl", 0, TAPS + PL, r);
    chk("t6_const", r, 27);

    // Reset in ISSUE k=2.
    push(18'd6, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    do_reset("rst_mid");
    wr_coefs(18'd1, 18'd2, 18'd3, 18'd4);
    push(18'd5, 0, 0, 0, 0);
    collect("t7", 0, TAPS + PL, r);
    chk("t7_const", r, 5);

    // Full-scale operands, no saturation.
    wr_coefs(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
    for (int i = 0; i < 4; i++) begin
      push(18'h3FFFF, 0, 0, 0, 0);
      collect("t8_max", 0, TAPS + PL, r);
    end
    chk("t8_const", r, 48'h3_FFFE_0000_4);

    // Randomized traffic with occasional writes, flushes and backpressure.
    wr_coefs(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    for (int i = 0; i < 24; i++) begin
      push(18'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           18'($urandom), ($urandom_range(0, 7) == 0));
      collect("rnd", $urandom_range(0, 3), TAPS + PL, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
